tcp_flag_tx: RTL
================

# tcp_flag_tx

Transmit-side segment flag scheduler paired with the TCP connection FSM. Accepts 4-bit flag requests (SYN/RST/FIN/ACK) from the connection FSM and queues them. Emits each request as a standard TCP flag byte over a valid/ready stream. Runs the retransmission timer for sequence-consuming segments (SYN, FIN) and raises `timo_strb` back to the FSM when retries are exhausted.

## Interface
Parameters:
- `DEPTH`, 4: request FIFO entries; power of 2, ≥2
- `TIMO_CYC`, 1000: cycles from handshake of a SYN/FIN segment to expiry; ≥2
- `MAX_RETX`, 3: retransmissions before giving up; 0..15

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `req_valid`  in  1  flag request valid
- `req_flags`  in  4  [3]=SYN [2]=RST [1]=FIN [0]=ACK
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `tx_valid`  out  1  flag byte valid
- `tx_data`  out  8  TCP flag byte: [4]=ACK [2]=RST [1]=SYN [0]=FIN, other bits 0
- `tx_ready`  in  1  downstream accepts byte
- `ack_rx`  in  1  single-cycle pulse: peer ACK received
- `timo_strb`  out  1  single-cycle pulse: retries exhausted
- `busy`  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Reset values: `req_ready`=0 while `rst` is high, then 1. `tx_valid`=0, `tx_data`=0, `timo_strb`=0, `busy`=0. FIFO is empty, retry count is 0, FSM is in IDLE.
- `req_ready` = FIFO not full. There is no same-cycle pass-through when full.
- Requests with `req_flags`=0 are accepted and discarded.
- An accepted request with RST=1 flushes all queued entries and is then written as the sole entry. If the FSM is in WAIT_ACK, it returns to IDLE, the retry count clears, and there is no `timo_strb`. If the FSM is in SEND, the in-flight byte completes unchanged.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the hold register and go to SEND.
  - SEND: `tx_valid`=1 and `tx_data`=encode(hold). Both are held stable until `tx_ready`. On handshake, if hold contains SYN or FIN, load the timer and go to WAIT_ACK; otherwise go to IDLE.
  - WAIT_ACK: the timer decrements and the FIFO is not popped (one outstanding segment).
    - On `ack_rx`: go to IDLE and clear the retry count.
    - On expiry with count < MAX_RETX: increment the count and go to SEND with the same hold.
    - On expiry with count = MAX_RETX: pulse `timo_strb`, clear the count, and go to IDLE.
- `ack_rx` outside WAIT_ACK is ignored.
- `ack_rx` in the expiry cycle: the ACK wins, with no retransmit and no strobe.
- Request push concurrent with IDLE pop: both take effect, and the count updates correctly.

## Timing
- Empty FIFO, IDLE: request accepted at cycle N, `tx_valid` rises at N+2.
- Back-to-back non-SYN/FIN entries: one byte per 2 cycles (SEND→IDLE→SEND).
- SYN/FIN handshake at cycle T, no ACK: expiry evaluated at T+TIMO_CYC. The retransmit `tx_valid` or the `timo_strb` is high at T+TIMO_CYC+1.
- `timo_strb` is registered, high for exactly one cycle.
- `rst` asserted mid-transfer: `tx_valid` drops immediately (async). Queued requests are lost.

## Structure
- Shared package `tcp_pkg`:
  - flag bit index constants (SYN=3, RST=2, FIN=1, ACK=0)
  - TCP flag byte positions
  - `tx_state_t` enum {IDLE, SEND, WAIT_ACK}
  - `flags_to_byte()` function
- The connection FSM also imports `tcp_pkg`, so flag ordering matches its state bits.
- Sub-module `tcp_flag_fifo`: synchronous FIFO with DEPTH entries, 4-bit data, and a `flush` input. The FSM, timer, and retry counter live in the top level.

## Test plan
- Single ACK request (flags=0001), `tx_ready`=1 → `tx_data`=0x10 at N+2. No WAIT_ACK, and `busy` drops 2 cycles after the handshake.
- SYN+ACK request (1001), `ack_rx` pulsed 10 cycles after handshake, TIMO_CYC=20 → one byte 0x12, no retransmit, no `timo_strb`.
- FIN request (0010), no `ack_rx`, MAX_RETX=3, TIMO_CYC=20 → 0x01 sent 4 times, 21 cycles apart (`tx_ready`=1). `timo_strb` pulses once, 21 cycles after the 4th handshake.
- Fill the FIFO with 4 ACK requests while `tx_ready`=0 → `req_ready`=0 on the 5th request. Then push RST (0100) once space frees → only the held byte, then 0x04, are emitted.
- `ack_rx` in exactly the expiry cycle of a SYN (1000) → no retransmit, no strobe, FSM in IDLE.
- `rst` asserted while `tx_valid`=1 with `tx_ready`=0 → `tx_valid`, `busy`, and `req_ready` are 0 in the same cycle. After release, the FIFO is empty.

Source files
------------

// File: rtl/tcp_pkg.sv
// Shared TCP definitions: flag request bit order, flag byte layout,
// transmit scheduler states and the request-to-byte encoder.
package tcp_pkg;

  // Bit positions inside a 4-bit flag request (matches connection FSM state bits)
  localparam int FLAG_SYN = 3;
  localparam int FLAG_RST = 2;
  localparam int FLAG_FIN = 1;
  localparam int FLAG_ACK = 0;

  // Bit positions inside the standard TCP header flag byte
  localparam int BYTE_FIN = 0;
  localparam int BYTE_SYN = 1;
  localparam int BYTE_RST = 2;
  localparam int BYTE_ACK = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } tx_state_t;

  // Map a 4-bit request onto the TCP flag byte; unused byte bits stay 0
  function automatic logic [7:0] flags_to_byte(input logic [3:0] flags);
    logic [7:0] b;
    b           = 8'h00;
    b[BYTE_SYN] = flags[FLAG_SYN];
    b[BYTE_RST] = flags[FLAG_RST];
    b[BYTE_FIN] = flags[FLAG_FIN];
    b[BYTE_ACK] = flags[FLAG_ACK];
    return b;
  endfunction

  // SYN and FIN consume sequence space and therefore need an ACK
  function automatic logic needs_ack(input logic [3:0] flags);
    return flags[FLAG_SYN] | flags[FLAG_FIN];
  endfunction

endpackage

// File: rtl/tcp_flag_fifo.sv
// Small synchronous FIFO for pending flag requests. A flush empties the
// queue; a push in the same cycle becomes the only remaining entry.
module tcp_flag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr_reg;
  ptr_t             rd_ptr_reg;
  cnt_t             count_reg;
  ptr_t             wr_addr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == cnt_t'(DEPTH));
  assign empty   = (count_reg == '0);
  // A flushing push always fits: the queue is emptied first
  assign push_ok = push && (flush || !full);
  // Nothing is popped from a queue that is being flushed
  assign pop_ok  = pop && !empty && !flush;
  assign wr_addr = flush ? '0 : wr_ptr_reg;
  assign rd_data = mem[rd_ptr_reg];

  // Storage array, no reset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= ptr_t'(push_ok);
      count_reg  <= cnt_t'(push_ok);
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + cnt_t'(push_ok) - cnt_t'(pop_ok);
    end
  end

endmodule

// File: rtl/tcp_flag_tx.sv
// Transmit-side flag scheduler: queues flag requests, emits TCP flag bytes
// on a valid/ready stream, and retransmits SYN/FIN until ACKed or retries run out.
module tcp_flag_tx
  import tcp_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int TIMO_CYC = 1000,
  parameter int MAX_RETX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_flags,
  output logic       req_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  input  logic       ack_rx,
  output logic       timo_strb,
  output logic       busy
);

  // Timer counts TIMO_CYC-1 down to 0, so clog2(TIMO_CYC) bits suffice
  localparam int TW = $clog2(TIMO_CYC);

  tx_state_t       state_reg;
  logic [3:0]      hold_reg;
  logic            tx_valid_reg;
  logic [7:0]      tx_data_reg;
  logic [TW-1:0]   timer_reg;
  logic [3:0]      retx_reg;
  logic            timo_reg;
  logic            busy_reg;
  logic            ready_en_reg;

  logic            fifo_full;
  logic            fifo_empty;
  logic [3:0]      fifo_rd;
  logic            req_accept;
  logic            fifo_push;
  logic            fifo_flush;
  logic            fifo_pop;

  assign req_ready  = ready_en_reg && !fifo_full;
  assign req_accept = req_valid && req_ready;
  // All-zero requests are accepted but never stored
  assign fifo_push  = req_accept && (req_flags != 4'b0000);
  assign fifo_flush = req_accept && req_flags[FLAG_RST];
  // A flush in IDLE defers the pop by one cycle so the RST entry is what gets sent
  assign fifo_pop   = (state_reg == IDLE) && !fifo_empty && !fifo_flush;

  tcp_flag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (req_flags),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_valid  = tx_valid_reg;
  assign tx_data   = tx_data_reg;
  assign timo_strb = timo_reg;
  assign busy      = busy_reg;

  // Scheduler FSM with retransmit timer, retry counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      hold_reg     <= 4'b0000;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      timer_reg    <= '0;
      retx_reg     <= 4'd0;
      timo_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      timo_reg     <= 1'b0;
      // busy reflects the previous cycle's state, so it trails the handshake by one cycle
      busy_reg     <= (state_reg != IDLE) || !fifo_empty;
      case (state_reg)
        IDLE: begin
          if (fifo_pop) begin
            hold_reg     <= fifo_rd;
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= flags_to_byte(fifo_rd);
            state_reg    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
            if (needs_ack(hold_reg)) begin
              timer_reg <= TW'(TIMO_CYC - 1);
              state_reg <= WAIT_ACK;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        WAIT_ACK: begin
          if (ack_rx || fifo_flush) begin
            // ACK beats a coincident expiry; RST abandons the segment silently
            retx_reg  <= 4'd0;
            state_reg <= IDLE;
          end else if (timer_reg == '0) begin
            if (retx_reg < 4'(MAX_RETX)) begin
              retx_reg     <= retx_reg + 4'd1;
              tx_valid_reg <= 1'b1;
              tx_data_reg  <= flags_to_byte(hold_reg);
              state_reg    <= SEND;
            end else begin
              timo_reg  <= 1'b1;
              retx_reg  <= 4'd0;
              state_reg <= IDLE;
            end
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
